// File: rtl/cu_multicycle.sv
// Multi-cycle RV32I-style control unit: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory-wait timeout, sticky halt causes and a retired-instruction counter.
module cu_multicycle #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter bit          SUPPORT_JUMP = 1'b1,
    parameter bit          SUPPORT_UI   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_fetch,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic        branch,
    output logic        illegal,
    output logic        timeout,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL, C_SYSTEM, C_BRANCH, C_LOAD, C_STORE, C_JALR,
        C_JAL, C_ARITH_I, C_ARITH_R, C_AUIPC, C_LUI
    } cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     st;
    cls_t       cls;
    cls_t       dec_cls;
    logic [7:0] wait_cnt;
    logic       unused_inst;

    assign state       = st;
    assign unused_inst = ^inst[31:7];

    always_comb begin
        dec_cls = C_ILLEGAL;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:2])
                5'b11000: dec_cls = C_BRANCH;
                5'b00000: dec_cls = C_LOAD;
                5'b01000: dec_cls = C_STORE;
                5'b11001: if (SUPPORT_JUMP) dec_cls = C_JALR;
                5'b11011: if (SUPPORT_JUMP) dec_cls = C_JAL;
                5'b00100: dec_cls = C_ARITH_I;
                5'b01100: dec_cls = C_ARITH_R;
                5'b00101: if (SUPPORT_UI) dec_cls = C_AUIPC;
                5'b01101: if (SUPPORT_UI) dec_cls = C_LUI;
                5'b11100: dec_cls = C_SYSTEM;
                default:  dec_cls = C_ILLEGAL;
            endcase
        end
    end

    // A ready on the last permitted wait cycle still completes the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_FETCH;
            cls      <= C_ILLEGAL;
            wait_cnt <= '0;
            retired  <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (mem_ready) begin
                        st <= S_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        st      <= S_HALT;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    if (dec_cls == C_ILLEGAL) begin
                        st      <= S_HALT;
                        illegal <= 1'b1;
                    end else if (dec_cls == C_SYSTEM) begin
                        st <= S_HALT;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_BRANCH: begin
                            st       <= S_FETCH;
                            wait_cnt <= '0;
                            retired  <= retired + 32'd1;
                        end
                        C_LOAD, C_STORE: begin
                            st       <= S_MEM;
                            wait_cnt <= '0;
                        end
                        default: st <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (cls == C_STORE) begin
                            st       <= S_FETCH;
                            wait_cnt <= '0;
                            retired  <= retired + 32'd1;
                        end else begin
                            st <= S_WB;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        st      <= S_HALT;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    st       <= S_FETCH;
                    wait_cnt <= '0;
                    retired  <= retired + 32'd1;
                end
                S_HALT:  st <= S_HALT;
                default: st <= S_HALT;
            endcase
        end
    end

    // Strobes decode from state and latched class; reset masks them at once.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        mem_to_reg   = 2'b00;
        branch       = 1'b0;
        if (rst_n) begin
            case (st)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    ir_write     = mem_ready;
                    pc_write     = mem_ready;
                end
                S_EXEC: begin
                    case (cls)
                        C_ARITH_R: alu_op = 2'b10;
                        C_ARITH_I: begin
                            alu_src_b = 2'b01;
                            alu_op    = 2'b10;
                        end
                        C_LOAD, C_STORE: alu_src_b = 2'b01;
                        C_BRANCH: begin
                            alu_op   = 2'b01;
                            branch   = 1'b1;
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                        C_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                        end
                        C_JALR: begin
                            alu_src_b = 2'b01;
                            pc_write  = 1'b1;
                            pc_src    = 2'b10;
                        end
                        C_LUI: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b01;
                        end
                        C_AUIPC: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (cls == C_STORE);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (cls == C_LOAD)
                        mem_to_reg = 2'b01;
                    else if (cls == C_JAL || cls == C_JALR)
                        mem_to_reg = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_multicycle.sv
// Bench for cu_multicycle: vector table, directed corner sequences and
// randomized instruction traces checked against a state-sequence model.
module tb_cu_multicycle;

    typedef enum logic [2:0] {
        S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5
    } st_e;

    typedef enum int {K_ILL, K_SYS, K_ALU, K_LOAD, K_STORE, K_BR, K_JMP} kind_e;

    typedef struct {
        logic [31:0] inst;
        int unsigned cycles;
        logic        rw;
        logic        we;
        logic [1:0]  m2r;
        logic [9:0]  ev;   // {alu_src_a, alu_src_b, alu_op, pc_write, pc_src, branch} in EXEC
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mem_ready;
    logic [31:0] inst;
    logic [2:0]  state;
    logic        mem_req, mem_we, mem_is_fetch, ir_write, pc_write, reg_write, branch;
    logic        illegal, timeout;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic [31:0] retired;

    logic        rst1_n, rdy1;
    logic [31:0] inst1;
    logic [2:0]  b_state;
    logic        b_mem_req, b_mem_we, b_mem_is_fetch, b_ir_write, b_pc_write, b_reg_write, b_branch;
    logic        b_illegal, b_timeout;
    logic [1:0]  b_pc_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_mem_to_reg;
    logic [31:0] b_retired;

    cu_multicycle u0 (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
        .state(state), .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch(branch),
        .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    cu_multicycle #(.MEM_WAIT_MAX(4), .SUPPORT_JUMP(1'b0), .SUPPORT_UI(1'b0)) u1 (
        .clk(clk), .rst_n(rst1_n), .inst(inst1), .mem_ready(rdy1),
        .state(b_state), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_is_fetch(b_mem_is_fetch),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
        .reg_write(b_reg_write), .mem_to_reg(b_mem_to_reg), .branch(b_branch),
        .illegal(b_illegal), .timeout(b_timeout), .retired(b_retired)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] model_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic kind_e model_kind(input logic [31:0] i, input bit jmp, input bit ui);
        if (i[1:0] != 2'b11) return K_ILL;
        case (i[6:2])
            5'b11000:          return K_BR;
            5'b00000:          return K_LOAD;
            5'b01000:          return K_STORE;
            5'b11001, 5'b11011: return jmp ? K_JMP : K_ILL;
            5'b00100, 5'b01100: return K_ALU;
            5'b00101, 5'b01101: return ui ? K_ALU : K_ILL;
            5'b11100:          return K_SYS;
            default:           return K_ILL;
        endcase
    endfunction

    // Starts at a falling edge with u0 in its first FETCH cycle; ends the same way.
    task automatic run_trace(input logic [31:0] i, input int unsigned d1, input int unsigned d2);
        st_e   sq[$];
        bit    rq[$];
        kind_e k;
        k = model_kind(i, 1'b1, 1'b1);
        repeat (d1) begin sq.push_back(S_F); rq.push_back(1'b0); end
        sq.push_back(S_F); rq.push_back(1'b1);
        sq.push_back(S_D); rq.push_back(1'($urandom_range(0, 1)));
        sq.push_back(S_E); rq.push_back(1'($urandom_range(0, 1)));
        if (k == K_LOAD || k == K_STORE) begin
            repeat (d2) begin sq.push_back(S_M); rq.push_back(1'b0); end
            sq.push_back(S_M); rq.push_back(1'b1);
        end
        if (k == K_LOAD || k == K_ALU || k == K_JMP) begin
            sq.push_back(S_W); rq.push_back(1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < sq.size(); n++) begin
            if (n > 0) @(negedge clk);
            inst      = i;
            mem_ready = rq[n];
            #1;
            chk("trace_state", 32'(state), 32'(sq[n]));
            chk("trace_reg_write", 32'(reg_write), 32'(sq[n] == S_W));
            chk("trace_mem_req", 32'(mem_req), 32'(sq[n] == S_F || sq[n] == S_M));
            chk("trace_ir_write", 32'(ir_write), 32'(sq[n] == S_F && rq[n]));
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        model_ret = model_ret + 32'd1;
        chk("trace_end_state", 32'(state), 32'(S_F));
        chk("trace_retired", retired, model_ret);
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned cyc = 0, rw = 0;
        logic        we  = 1'b0;
        logic [1:0]  m2r = 2'b00;
        logic [9:0]  ev  = '0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            else begin
                inst      = v.inst;
                mem_ready = 1'b1;
            end
            #1;
            if (k > 0 && state == 3'd0) begin
                cyc = k;
                break;
            end
            if (state == 3'd2) ev = {alu_src_a, alu_src_b, alu_op, pc_write, pc_src, branch};
            if (reg_write) begin
                rw++;
                m2r = mem_to_reg;
            end
            if (mem_we) we = 1'b1;
        end
        model_ret = model_ret + 32'd1;
        chk("vec_cycles", cyc, v.cycles);
        chk("vec_reg_write_count", rw, 32'(v.rw));
        chk("vec_mem_we", 32'(we), 32'(v.we));
        chk("vec_mem_to_reg", 32'(m2r), 32'(v.m2r));
        chk("vec_exec_ctrl", 32'(ev), 32'(v.ev));
        chk("vec_retired", retired, model_ret);
    endtask

    task automatic reset0();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'(S_F));
        chk("rst_flags", {30'd0, illegal, timeout}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_ret = '0;
    endtask

    initial begin
        vec_t        tbl[9];
        logic [4:0]  opc[9];
        logic [31:0] r;

        rst_n = 1'b0; inst = '0; mem_ready = 1'b1;
        rst1_n = 1'b0; inst1 = '0; rdy1 = 1'b0;
        model_ret = '0;

        tbl[0] = '{32'h002081B3, 4, 1'b1, 1'b0, 2'b00, 10'b00_00_10_0_00_0};
        tbl[1] = '{32'h00108093, 4, 1'b1, 1'b0, 2'b00, 10'b00_01_10_0_00_0};
        tbl[2] = '{32'h0000A283, 5, 1'b1, 1'b0, 2'b01, 10'b00_01_00_0_00_0};
        tbl[3] = '{32'h0050A223, 4, 1'b0, 1'b1, 2'b00, 10'b00_01_00_0_00_0};
        tbl[4] = '{32'h00208063, 3, 1'b0, 1'b0, 2'b00, 10'b00_00_01_1_01_1};
        tbl[5] = '{32'h0000006F, 4, 1'b1, 1'b0, 2'b10, 10'b00_00_00_1_10_0};
        tbl[6] = '{32'h00008067, 4, 1'b1, 1'b0, 2'b10, 10'b00_01_00_1_10_0};
        tbl[7] = '{32'h000012B7, 4, 1'b1, 1'b0, 2'b00, 10'b10_01_00_0_00_0};
        tbl[8] = '{32'h00001297, 4, 1'b1, 1'b0, 2'b00, 10'b01_01_00_0_00_0};
        opc = '{5'b11000, 5'b00000, 5'b01000, 5'b11001, 5'b11011,
                5'b00100, 5'b01100, 5'b00101, 5'b01101};

        // Reset: strobes masked even with mem_ready high in FETCH.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'(S_F));
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_ir_write", 32'(ir_write), 32'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_flags", {30'd0, illegal, timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_fetch_req", {30'd0, mem_req, mem_is_fetch}, 32'd3);

        foreach (tbl[i]) run_vec(tbl[i]);

        run_trace(32'h0000A283, 0, 3);

        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            run_trace({r[31:7], opc[$urandom_range(0, 8)], 2'b11},
                      $urandom_range(0, 5), $urandom_range(0, 5));
        end

        // Counter wrap from a preloaded all-ones value.
        force u0.retired = 32'hFFFF_FFFF;
        #1;
        release u0.retired;
        chk("wrap_preload", retired, 32'hFFFF_FFFF);
        model_ret = 32'hFFFF_FFFF;
        run_trace(32'h002081B3, 0, 0);
        chk("wrap_zero", retired, 32'd0);

        // Reset asserted while a load waits in MEM abandons the request.
        inst = 32'h0000A283;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("midmem_state", 32'(state), 32'(S_M));
        chk("midmem_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midmem_rst_req", 32'(mem_req), 32'd0);
        chk("midmem_rst_state", 32'(state), 32'(S_F));
        @(negedge clk);
        rst_n = 1'b1;
        model_ret = '0;

        // Illegal encoding halts stickily; mem_ready in HALT is ignored.
        inst = 32'h0000_0000;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("ill_decode", 32'(state), 32'(S_D));
        @(negedge clk);
        #1;
        chk("ill_halt", 32'(state), 32'(S_H));
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_strobes", {28'd0, mem_req, ir_write, pc_write, reg_write}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("ill_sticky", {28'd0, state, illegal}, {28'd0, 3'(S_H), 1'b1});
        reset0();

        inst = 32'h0000_0073;
        repeat (2) @(negedge clk);
        #1;
        chk("sys_halt", 32'(state), 32'(S_H));
        chk("sys_not_illegal", 32'(illegal), 32'd0);
        reset0();

        // u1: MEM_WAIT_MAX=4, jumps and upper-immediates disabled.
        @(negedge clk);
        rst1_n = 1'b1;
        inst1 = 32'h002081B3;
        rdy1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("to_wait3_state", 32'(b_state), 32'(S_F));
        chk("to_wait3_flag", 32'(b_timeout), 32'd0);
        @(negedge clk);
        #1;
        chk("to_halt_state", 32'(b_state), 32'(S_H));
        chk("to_halt_flag", 32'(b_timeout), 32'd1);
        chk("to_halt_req", 32'(b_mem_req), 32'd0);
        rst1_n = 1'b0;
        #1;
        chk("to_rst_flag", 32'(b_timeout), 32'd0);
        @(negedge clk);
        rst1_n = 1'b1;
        inst1 = 32'h0000006F;
        repeat (3) @(negedge clk);
        rdy1 = 1'b1;
        #1;
        chk("to_last_ir_write", 32'(b_ir_write), 32'd1);
        @(negedge clk);
        rdy1 = 1'b0;
        #1;
        chk("to_last_state", 32'(b_state), 32'(S_D));
        chk("to_last_flag", 32'(b_timeout), 32'd0);
        @(negedge clk);
        #1;
        chk("nojump_halt", {28'd0, b_state, b_illegal}, {28'd0, 3'(S_H), 1'b1});
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        inst1 = 32'h000012B7;
        rdy1 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("noui_halt", {28'd0, b_state, b_illegal}, {28'd0, 3'(S_H), 1'b1});
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        inst1 = 32'h0000A283;
        repeat (3) @(negedge clk);
        rdy1 = 1'b0;
        #1;
        chk("memto_enter", 32'(b_state), 32'(S_M));
        repeat (3) @(negedge clk);
        #1;
        chk("memto_wait3", 32'(b_state), 32'(S_M));
        @(negedge clk);
        #1;
        chk("memto_halt", {28'd0, b_state, b_timeout}, {28'd0, 3'(S_H), 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
